// File: rtl/mul_iter_unit.sv
// mul_iter_unit: iterative radix-2^BITS_PER_CYCLE multiplier with a
// three-state control FSM (IDLE -> RUN -> DONE). Operand magnitudes are
// multiplied digit by digit into a 2*DATA_W accumulator. The sign is
// applied once, when the product is complete.
//
// Optional feature: define MUL_ITER_EARLY_ZERO_EN so that a zero operand
// skips RUN and completes in a single cycle with result 0.
module mul_iter_unit #(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              start,
    input  logic              flush,
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [4:0]        rd_in,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        rd_out,
    output logic              done,
    output logic              busy,
    output logic              stall
);

    localparam int N     = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;
    localparam int PW    = 2 * DATA_W;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     acc_d;
    logic [PW-1:0]     mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic              neg_q;
    logic [2:0]        func3_q;
    logic [4:0]        tag_q;
    logic [DATA_W-1:0] result_q;
    logic [4:0]        rd_q;
    logic              done_q;
    logic              busy_q;

    logic              a_signed;
    logic              b_signed;
    logic              neg_d;
    logic              high_q;
    logic              last_digit;
    logic              accept;
    logic              zero_op;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;

    // Two's-complement magnitude; the most negative value maps to 2^(DATA_W-1),
    // which is representable as an unsigned DATA_W-bit number.
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic is_signed);
        if (is_signed && v[DATA_W-1]) begin
            return DATA_W'(-v);
        end
        return DATA_W'(v);
    endfunction

    // Apply the sign to the full-width product, then select the requested half.
    function automatic logic [DATA_W-1:0] select_result(input logic [PW-1:0] prod,
                                                        input logic neg,
                                                        input logic high);
        logic [PW-1:0] p;
        p = neg ? (~prod + PW'(1)) : prod;
        return high ? p[PW-1:DATA_W] : p[DATA_W-1:0];
    endfunction

`ifdef MUL_ITER_EARLY_ZERO_EN
    assign zero_op = (op_a == '0) || (op_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Operand decode for an incoming request, plus the per-cycle accumulator step.
    always_comb begin
        a_signed   = (func3 == F_MULH) || (func3 == F_MULHSU);
        b_signed   = (func3 == F_MULH);
        mag_a      = magnitude(op_a, a_signed);
        mag_b      = magnitude(op_b, b_signed);
        neg_d      = (a_signed & op_a[DATA_W-1]) ^ (b_signed & op_b[DATA_W-1]);
        high_q     = (func3_q == F_MULH) || (func3_q == F_MULHSU) || (func3_q == F_MULHU);
        last_digit = (cnt_q == CNT_W'(N - 1));
        accept     = (state_q == S_IDLE) && start && enable && !flush;
        acc_d      = acc_q + mcand_q * PW'(mplier_q[BITS_PER_CYCLE-1:0]);
    end

    // Control FSM together with the datapath registers it sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            func3_q  <= '0;
            tag_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (enable) begin
            if (flush) begin
                state_q <= S_IDLE;
                done_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (zero_op) begin
                                state_q  <= S_DONE;
                                result_q <= '0;
                                rd_q     <= rd_in;
                                done_q   <= 1'b1;
                                busy_q   <= 1'b1;
                            end else begin
                                state_q  <= S_RUN;
                                mcand_q  <= PW'(mag_a);
                                mplier_q <= mag_b;
                                neg_q    <= neg_d;
                                func3_q  <= func3;
                                tag_q    <= rd_in;
                                acc_q    <= '0;
                                cnt_q    <= '0;
                                busy_q   <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << BITS_PER_CYCLE;
                        mplier_q <= mplier_q >> BITS_PER_CYCLE;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (last_digit) begin
                            state_q  <= S_DONE;
                            result_q <= select_result(acc_d, neg_q, high_q);
                            rd_q     <= tag_q;
                            done_q   <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign result = result_q;
    assign rd_out = rd_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign stall  = accept || (state_q == S_RUN);

endmodule

// File: tb/tb_mul_iter_unit.sv
// Self-checking bench for mul_iter_unit (DATA_W=64, BITS_PER_CYCLE=4).
// A cycle-level behavioural model predicts every output and is compared on
// each falling edge; directed cases pin known results and latencies.
module tb_mul_iter_unit;

    localparam int W = 64;
    localparam int NCYC = 16;
`ifdef MUL_ITER_EARLY_ZERO_EN
    localparam bit EZ = 1'b1;
`else
    localparam bit EZ = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         enable;
    logic         start;
    logic         flush;
    logic [2:0]   func3;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [4:0]   rd_in;
    logic [W-1:0] result;
    logic [4:0]   rd_out;
    logic         done;
    logic         busy;
    logic         stall;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mul_iter_unit #(.DATA_W(W), .BITS_PER_CYCLE(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .flush(flush),
        .func3(func3), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .result(result), .rd_out(rd_out), .done(done), .busy(busy), .stall(stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference product: extend each operand to 128 bits according to its
    // signedness and take the wrapped 128-bit product.
    function automatic logic [W-1:0] ref_mul(input logic [2:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] ax, bx, p;
        ax = {{W{1'b0}}, a};
        bx = {{W{1'b0}}, b};
        if (f == 3'd1) begin
            ax = {{W{a[W-1]}}, a};
            bx = {{W{b[W-1]}}, b};
        end else if (f == 3'd2) begin
            ax = {{W{a[W-1]}}, a};
        end
        p = ax * bx;
        if (f == 3'd1 || f == 3'd2 || f == 3'd3) return p[2*W-1:W];
        return p[W-1:0];
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 running, 2 done.
    int           ph = 0;
    int           rem = 0;
    logic [W-1:0] exp_result = '0;
    logic [4:0]   exp_rd = '0;
    logic [W-1:0] pend_res = '0;
    logic [4:0]   pend_rd = '0;

    always @(posedge clk) begin
        if (rst) begin
            ph = 0;
            exp_result = '0;
            exp_rd = '0;
        end else if (enable) begin
            if (flush) begin
                ph = 0;
            end else if (ph == 0) begin
                if (start) begin
                    if (EZ && (op_a == '0 || op_b == '0)) begin
                        ph = 2;
                        exp_result = '0;
                        exp_rd = rd_in;
                    end else begin
                        ph = 1;
                        rem = NCYC;
                        pend_res = ref_mul(func3, op_a, op_b);
                        pend_rd = rd_in;
                    end
                end
            end else if (ph == 1) begin
                rem--;
                if (rem == 0) begin
                    ph = 2;
                    exp_result = pend_res;
                    exp_rd = pend_rd;
                end
            end else begin
                ph = 0;
            end
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_result", result, exp_result);
            chk("m_rd", W'(rd_out), W'(exp_rd));
            chk("m_done", W'(done), W'(ph == 2));
            chk("m_busy", W'(busy), W'(ph != 0));
            chk("m_stall", W'(stall), W'((ph == 0 && start && enable && !flush) || ph == 1));
        end
    end

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return W'(1);
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Issue one op in the current cycle t; return cycles until done is seen.
    task automatic do_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd, output int lat);
        next_cycle();
        start = 1'b1; func3 = f; op_a = a; op_b = b; rd_in = rd;
        next_cycle();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            next_cycle();
            lat++;
        end
        if (lat >= 100) begin
            errors++;
            $display("FAIL op_timeout actual=%0d required=<100", lat);
        end
    endtask

    initial begin
        int lat;
        int c;
        int dcnt;
        rst = 1'b1; enable = 1'b1; start = 1'b0; flush = 1'b0;
        func3 = 3'd0; op_a = '0; op_b = '0; rd_in = '0;
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        chk("rst_result", result, '0);
        chk("rst_rd", W'(rd_out), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_stall", W'(stall), '0);
        next_cycle();
        rst = 1'b0;

        // Directed cases with hand-computed results.
        do_op(3'd0, 64'd7, 64'd6, 5'd9, lat);
        chk("mul7x6_lat", W'(lat), W'(17));
        chk("mul7x6", result, 64'd42);
        chk("mul7x6_rd", W'(rd_out), W'(9));
        do_op(3'd1, '1, '1, 5'd1, lat);
        chk("mulh_m1", result, 64'd0);
        do_op(3'd3, '1, '1, 5'd2, lat);
        chk("mulhu_max", result, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd3, lat);
        chk("mulhsu_m2x3", result, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(3'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd4, lat);
        chk("mul_m2x3", result, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(3'd1, {1'b1, 63'd0}, {1'b1, 63'd0}, 5'd5, lat);
        chk("mulh_min", result, 64'h4000_0000_0000_0000);
        do_op(3'd0, 64'd7, 64'd6, 5'd9, lat);

        // Flush at t+5: no done, held outputs unchanged.
        next_cycle();
        start = 1'b1; func3 = 3'd0; op_a = 64'd11; op_b = 64'd13; rd_in = 5'd3;
        next_cycle();
        start = 1'b0;
        repeat (3) next_cycle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        chk("flush_busy", W'(busy), '0);
        chk("flush_result", result, 64'd42);
        chk("flush_rd", W'(rd_out), W'(9));
        dcnt = 0;
        repeat (20) begin
            next_cycle();
            if (done) dcnt++;
        end
        chk("flush_nodone", W'(dcnt), '0);

        // Enable low for three RUN cycles: done moves to t+20.
        next_cycle();
        start = 1'b1; func3 = 3'd3; op_a = 64'd100; op_b = 64'd200; rd_in = 5'd17;
        next_cycle();
        start = 1'b0;
        c = 1;
        while (!done && c < 100) begin
            next_cycle();
            c++;
            if (c == 4) enable = 1'b0;
            if (c == 7) enable = 1'b1;
        end
        enable = 1'b1;
        chk("enable_gap_lat", W'(c), W'(20));
        chk("enable_gap_res", result, 64'd0);
        chk("enable_gap_rd", W'(rd_out), W'(17));

        // Reset at t+8: everything zero, no done afterwards.
        next_cycle();
        start = 1'b1; func3 = 3'd0; op_a = 64'd5; op_b = 64'd5; rd_in = 5'd6;
        next_cycle();
        start = 1'b0;
        repeat (6) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("midrst_result", result, '0);
        chk("midrst_rd", W'(rd_out), '0);
        chk("midrst_done", W'(done), '0);
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_stall", W'(stall), '0);
        dcnt = 0;
        repeat (20) begin
            next_cycle();
            if (done) dcnt++;
        end
        chk("midrst_nodone", W'(dcnt), '0);

        // Zero operand latency depends on the early-zero option.
        do_op(3'd0, 64'd0, 64'h1234, 5'd4, lat);
        chk("zero_lat", W'(lat), EZ ? W'(1) : W'(17));
        chk("zero_res", result, '0);
        chk("zero_rd", W'(rd_out), W'(4));

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rst    = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 99) < 85);
            flush  = ($urandom_range(0, 99) < 2);
            start  = ($urandom_range(0, 99) < 30);
            func3  = 3'($urandom_range(0, 7));
            op_a   = rand_op();
            op_b   = rand_op();
            rd_in  = 5'($urandom_range(0, 31));
        end
        next_cycle();
        rst = 1'b0; enable = 1'b1; flush = 1'b0; start = 1'b0;
        repeat (20) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_iter_unit.md
MUL_ITER_UNIT -- requirements
Module: mul_iter_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64, operand/result width.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 4, multiplier bits retired per cycle; legal values 1, 2, 4, 8; DATA_W SHALL be a multiple of it.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable  input  1  pipeline enable; when low, all state is frozen.
REQ-006 SHALL have port start  input  1  request a multiply; sampled in IDLE only.
REQ-007 SHALL have port flush  input  1  abort the in-flight operation.
REQ-008 SHALL have port func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; other codes behave as MUL.
REQ-009 SHALL have ports op_a, op_b  input  DATA_W  multiplicand and multiplier.
REQ-010 SHALL have port rd_in  input  5  destination register tag.
REQ-011 SHALL have port result  output  DATA_W  registered result.
REQ-012 SHALL have port rd_out  output  5  tag of the operation that produced result.
REQ-013 SHALL have port done  output  1  high exactly while the FSM is in DONE.
REQ-014 SHALL have port busy  output  1  high when state is not IDLE.
REQ-015 SHALL have port stall  output  1  pipeline hold request.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; with enable low no transition, counter or datapath update occurs.
REQ-017 IDLE: start&enable&!flush SHALL latch |op_a|, |op_b|, result sign, func3 and rd_in, clear the accumulator and counter, and go to RUN.
REQ-018 Signedness: MULH both signed; MULHSU op_a signed, op_b unsigned; MULHU and MUL unsigned magnitudes; -2^(DATA_W-1) SHALL be handled as magnitude 2^(DATA_W-1).
REQ-019 RUN: each enabled cycle SHALL add multiplicand times the next BITS_PER_CYCLE multiplier bits, suitably shifted, into a 2*DATA_W accumulator and increment the counter.
REQ-020 After N = DATA_W/BITS_PER_CYCLE RUN cycles the FSM SHALL go to DONE, registering result and rd_out.
REQ-021 result SHALL be the low DATA_W bits of the product for MUL and the high DATA_W bits for MULH/MULHSU/MULHU, after 2*DATA_W two's-complement negation when the sign is negative.
REQ-022 Latency: start accepted at edge t SHALL give done high during cycle t+N+1, with no enable gaps.
REQ-023 DONE SHALL return to IDLE on the next enabled edge; start in DONE or RUN SHALL be ignored.
REQ-024 stall SHALL equal (IDLE & start & enable & !flush) | RUN; it SHALL be low in DONE so the pipeline advances with result.
REQ-025 result and rd_out SHALL hold their values until the next completion.
REQ-026 flush in any state SHALL force IDLE on the next edge without pulsing done and without changing result or rd_out; flush wins over a simultaneous start.

Reset
REQ-027 rst high at an edge SHALL force IDLE, clear the counter and accumulator, and set result, rd_out, done, busy and stall to 0, regardless of enable.
REQ-028 rst mid-RUN SHALL discard the operation; no done pulse SHALL follow.

Configuration
REQ-029 Macro MUL_ITER_EARLY_ZERO_EN, when defined, SHALL send a start with op_a==0 or op_b==0 directly IDLE->DONE with result 0 and rd_out=rd_in, so done is high in cycle t+1.
REQ-030 Without MUL_ITER_EARLY_ZERO_EN every operation SHALL take the full N+1 latency.

Verification (DATA_W=64, BITS_PER_CYCLE=4, N=16)
REQ-031 MUL 7 x 6, start at t -> stall high t..t+16, done only in t+17, result 42.
REQ-032 MULH -1 x -1 -> result 0; MULHU 0xFFFFFFFFFFFFFFFF x 0xFFFFFFFFFFFFFFFF -> result 0xFFFFFFFFFFFFFFFE.
REQ-033 MULHSU op_a=-2, op_b=3 -> result 0xFFFFFFFFFFFFFFFF; MUL with the same operands -> 0xFFFFFFFFFFFFFFFA.
REQ-034 Start at t, flush at t+5 -> busy low from t+6, no done pulse, result and rd_out unchanged.
REQ-035 Start at t, enable low for 3 cycles in RUN -> done in t+20; rst asserted at t+8 instead -> all outputs 0 from t+9, no done.
REQ-036 MUL 0 x 0x1234 -> done in t+1, result 0 with MUL_ITER_EARLY_ZERO_EN; done in t+17, result 0 without.
